string_detector_mode2: RTL and testbench

Serial pattern counter: compares a 1-bit serial input stream against a 4-bit reference pattern and counts matches. The count is exposed on a 4-bit saturating output. The block sits between a bit-serial data source and any consumer of the match count. It is a standalone leaf with one clock domain.

---
 rtl/string_detector_mode2.sv | 45 ++++
 tb/tb_string_detector_mode2.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/string_detector_mode2.sv
// Serial 4-bit pattern match counter with a saturating 4-bit count.
// Define STR_DET_OVERLAP_EN to count overlapping matches; the default is non-overlapping.
module string_detector_mode2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] string1,
  input  logic       string2,
  output logic [3:0] N
);

  logic [2:0] win;
  logic [2:0] fill;
  logic [3:0] cnt;
  logic [3:0] cand;
  logic       hit;

  assign cand = {win, string2};
  // An X/Z data bit makes the compare unknown, which the if() below treats as no hit.
  assign hit  = (fill >= 3'd3) && (cand == string1);
  assign N    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win  <= 3'd0;
      fill <= 3'd0;
      cnt  <= 4'd0;
    end else begin
      win <= cand[2:0];
      if (fill != 3'd4) begin
        fill <= fill + 3'd1;
      end
      if (hit) begin
        if (cnt != 4'd15) begin
          cnt <= cnt + 4'd1;
        end
`ifdef STR_DET_OVERLAP_EN
`else
        // Consumed bits cannot seed the next match.
        fill <= 3'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_string_detector_mode2.sv
// Directed bench for string_detector_mode2: a queue-based model of the matching rules is
// compared against N every cycle, plus literal expectations from hand-worked streams.
module tb_string_detector_mode2;

  logic       clk;
  logic       rst_n;
  logic [3:0] string1;
  logic       string2;
  logic [3:0] N;

  int checks;
  int errors;
  int model_n;
  bit hist[$];

`ifdef STR_DET_OVERLAP_EN
  localparam bit Overlap = 1'b1;
`else
  localparam bit Overlap = 1'b0;
`endif

  string_detector_mode2 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .string1 (string1),
    .string2 (string2),
    .N       (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: keep only bits received since the last clear; a match needs 4 of them.
  task automatic model_bit(input bit b, input logic [3:0] pat);
    logic [3:0] last4;
    hist.push_back(b);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() == 4) begin
      last4 = {hist[0], hist[1], hist[2], hist[3]};
      if (last4 == pat) begin
        if (model_n < 15) model_n = model_n + 1;
        if (!Overlap) hist.delete();
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checks = checks + 1;
    if (int'(N) != model_n) begin
      errors = errors + 1;
      $display("FAIL model_compare t=%0t: got %0d expected %0d", $time, N, model_n);
    end
  end

  task automatic step(input logic b);
    logic [3:0] pat;
    string2 = b;
    pat = string1;
    @(posedge clk);
    model_bit(b, pat);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hist.delete();
    model_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [19:0] s1;
  int sat_bit;

  initial begin
    checks  = 0;
    errors  = 0;
    model_n = 0;
    string1 = 4'b0110;
    string2 = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("reset_n", int'(N), 0);
    do_reset();

    // Pattern 0110, 20-bit stream
    s1 = 20'b0110_0110_0001_1011_0001;
    for (int i = 0; i < 20; i++) begin
      step(s1[19-i]);
      if (!Overlap && i == 3)  check("p0110_bit3", int'(N), 1);
      if (!Overlap && i == 7)  check("p0110_bit7", int'(N), 2);
      if (!Overlap && i == 13) check("p0110_bit13", int'(N), 3);
      if (i == 2) check("p0110_bit2", int'(N), 0);
    end
    check("p0110_final", int'(N), Overlap ? 4 : 3);

    // Pattern 1111, eight ones
    do_reset();
    string1 = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      if (i == 3) check("p1111_bit3", int'(N), 1);
    end
    check("p1111_final", int'(N), Overlap ? 5 : 2);

    // Pattern 0000, 80 zeros: saturation
    do_reset();
    string1 = 4'b0000;
    sat_bit = Overlap ? 17 : 59;
    for (int i = 0; i < 80; i++) begin
      step(1'b0);
      if (i == sat_bit - 1) check("sat_before", int'(N), 14);
      if (i == sat_bit)     check("sat_reach", int'(N), 15);
    end
    check("sat_hold", int'(N), 15);

    // Reset mid-match, starting from a saturated count
    string1 = 4'b0110;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    check("pre_reset", int'(N), 15);
    #2;
    rst_n = 1'b0;
    hist.delete();
    model_n = 0;
    #1;
    check("async_reset", int'(N), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    check("post_reset_no_hit", int'(N), 0);

    // Pattern change before the 4th edge
    do_reset();
    string1 = 4'b0110;
    step(1'b1);
    step(1'b0);
    step(1'b1);
    string1 = 4'b1010;
    step(1'b0);
    check("pattern_change", int'(N), 1);

    // Fill guard
    do_reset();
    string1 = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("fill_guard_early", int'(N), 0);
    end
    step(1'b0);
    check("fill_guard_4th", int'(N), 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
